// File: rtl/spi_pkg.sv
// Shared types and constants for the spi_mem_ctrl SPI SRAM master.
// Build option: SPI_FAST_READ_EN adds the DUMMY phase and 0x0B reads.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
`ifdef SPI_FAST_READ_EN
    DUMMY = 3'd3,
`endif
    DATA  = 3'd4,
    FIN   = 3'd5,
    ACK   = 3'd6
  } spi_state_t;

  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE     = 8'h02;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

  localparam logic [4:0] CMD_BITS   = 5'd8;
  localparam logic [4:0] ADDR_BITS  = 5'd16;
  localparam logic [4:0] DUMMY_BITS = 5'd8;
  localparam logic [4:0] DATA_BITS  = 5'd8;

  // Byte phases use the upper half of the 16-bit shifter.
  function automatic logic [15:0] msb_align8(
    input logic [7:0] b
  );
    return {b, 8'h00};
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_bit_engine.sv
// spi_bit_engine: SCLK divider, MSB-first shifter and bit counter
// for one phase; raises phase_done on the edge that ends its last bit.
module spi_bit_engine
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] ld_data,
  input  logic [4:0]  ld_len,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        phase_done,
  output logic [7:0]  rx_byte
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic [15:0]   sh_q, sh_d;
  logic [4:0]    bit_q, bit_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    rx_q, rx_d;

  logic tick;
  logic last_bit;

  assign tick       = (div_q == DIV_MAX);
  assign last_bit   = (bit_q == len_q - 5'd1);
  assign phase_done = en & sclk_q & tick & last_bit;

  assign sclk    = sclk_q;
  assign mosi    = sh_q[15];
  assign rx_byte = rx_q;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    len_d  = len_q;
    rx_d   = rx_q;
    if (load) begin
      div_d  = '0;
      sclk_d = 1'b0;
      sh_d   = ld_data;
      bit_d  = '0;
      len_d  = ld_len;
    end else if (!en || phase_done) begin
      div_d  = '0;
      sclk_d = 1'b0;
      sh_d   = '0;
      bit_d  = '0;
    end else if (!tick) begin
      div_d = div_q + 1'b1;
    end else begin
      div_d = '0;
      if (!sclk_q) begin
        // Rising SCLK: miso is captured on this same clk edge.
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso};
      end else begin
        sclk_d = 1'b0;
        sh_d   = {sh_q[14:0], 1'b0};
        bit_d  = bit_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      sh_q   <= '0;
      bit_q  <= '0;
      len_q  <= '0;
      rx_q   <= '0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      len_q  <= len_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: one-byte read/write master for 23LC-style SPI SRAM.
// Build option: SPI_FAST_READ_EN selects 0x0B reads with 8 dummy bits.
module spi_mem_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] RD_CMD = SPI_CMD_FAST_READ;
`else
  localparam logic [7:0] RD_CMD = SPI_CMD_READ;
`endif

  spi_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;

  logic        eng_en;
  logic        load;
  logic [15:0] ld_data;
  logic [4:0]  ld_len;
  logic        phase_done;
  logic [7:0]  rx_byte;
  logic [15:0] addr16;

  assign addr16 = 16'(addr_q);

`ifdef SPI_FAST_READ_EN
  assign eng_en = (state_q == CMD) || (state_q == ADDR) ||
                  (state_q == DUMMY) || (state_q == DATA);
`else
  assign eng_en = (state_q == CMD) || (state_q == ADDR) ||
                  (state_q == DATA);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    cs_n_d  = cs_n_q;
    load    = 1'b0;
    ld_data = '0;
    ld_len  = DATA_BITS;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          cs_n_d  = 1'b0;
          load    = 1'b1;
          ld_data = msb_align8(we ? SPI_CMD_WRITE : RD_CMD);
          ld_len  = CMD_BITS;
          state_d = CMD;
        end
      end
      CMD: begin
        if (phase_done) begin
          load    = 1'b1;
          ld_data = addr16;
          ld_len  = ADDR_BITS;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (phase_done) begin
          // Reads shift out zeros while sampling miso.
          load    = 1'b1;
          ld_data = msb_align8(we_q ? wdata_q : 8'h00);
          ld_len  = DATA_BITS;
          state_d = DATA;
`ifdef SPI_FAST_READ_EN
          if (!we_q) begin
            ld_len  = DUMMY_BITS;
            state_d = DUMMY;
          end
`endif
        end
      end
`ifdef SPI_FAST_READ_EN
      DUMMY: begin
        if (phase_done) begin
          load    = 1'b1;
          ld_data = '0;
          ld_len  = DATA_BITS;
          state_d = DATA;
        end
      end
`endif
      DATA: begin
        if (phase_done) begin
          cs_n_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN: begin
        if (!we_q) rdata_d = rx_byte;
        done_d  = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        done_d  = 1'b0;
        cs_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
    end
  end

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_eng (
    .clk        (clk),
    .rst        (rst),
    .en         (eng_en),
    .load       (load),
    .ld_data    (ld_data),
    .ld_len     (ld_len),
    .miso       (miso),
    .sclk       (sclk),
    .mosi       (mosi),
    .phase_done (phase_done),
    .rx_byte    (rx_byte)
  );

  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);
  assign cs_n  = cs_n_q;

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- Byte-wide SPI master that serves the control unit's fetch/operand handshake.
- On request it reads or writes one byte of external 23LC-style SPI SRAM at a 16-bit address: instruction fetch at pc, operand/data access otherwise.
- Sits between the control unit (start = spi_executing, done = spi_done, rdata → ir/operand path) and the chip pins.

Parameters:
- CLK_DIV, 1, clk cycles per SCLK half-period (≥1).
- ADDR_W, 16, address width; sent MSB-first as 16 bits, zero-extended.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  level request; sampled only in IDLE
- addr  input  ADDR_W  byte address; latched at start
- we  input  1  1 = write, 0 = read; latched at start
- wdata  input  8  write byte; latched at start
- done  output  1  transfer complete; 4-phase handshake
- rdata  output  8  last byte read; holds until next read completes
- busy  output  1  high in any state except IDLE
- sclk  output  1  SPI clock, mode 0 (idle low)
- cs_n  output  1  chip select, active low
- mosi  output  1  serial out
- miso  input  1  serial in

Behaviour:
- Reset values: done=0, rdata=0, busy=0, sclk=0, cs_n=1, mosi=0, state=IDLE, counters 0. Reset mid-transfer aborts immediately; pins return to idle asynchronously.
- States: IDLE, CMD, ADDR, DATA, FIN, ACK.
- IDLE: when start=1, latch addr/we/wdata, drive cs_n=0, and go to CMD.
- CMD: shift 8 bits, 0x02 for write or 0x03 for read.
- ADDR: shift 16 address bits, MSB first.
- DATA: write shifts out wdata; read shifts in 8 bits from miso, MSB first.
- Bit timing: each bit lasts 2*CLK_DIV clk cycles.
  - mosi is updated at bit start while sclk=0.
  - sclk rises after CLK_DIV cycles; miso is sampled on the clk edge that raises sclk.
  - sclk falls at bit end.
- FIN (1 cycle): cs_n=1, sclk=0. On a read, rdata ← shifted byte. Then go to ACK.
- ACK: done=1; hold until start=0, then go to IDLE with done=0 on the same edge.
  - If start is already 0 on entry, done is high for exactly 1 cycle.
- Latency: start sampled high → done high = 1 + 32*2*CLK_DIV + 1 cycles (66 at CLK_DIV=1).
- Changes to start/addr/we/wdata after latching are ignored until IDLE. A start deassert mid-transfer does not abort.
- Back-to-back transfers: minimum one IDLE cycle between transfers; cs_n high for ≥2 cycles.
- A write leaves rdata unchanged.
- Bit counter wraps only within a phase. No state is reachable other than those listed; an illegal encoding returns to IDLE.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined: reads use command 0x0B followed by 8 dummy bits (mosi=0) after the address. Read latency becomes 1 + 40*2*CLK_DIV + 1 cycles. Writes are unchanged.
- Undefined: reads use 0x03 with no dummy phase; the DUMMY state is not present.

Decomposition:
- Package spi_pkg holds:
  - state enum spi_state_t (IDLE, CMD, ADDR, DUMMY, DATA, FIN, ACK)
  - constants SPI_CMD_READ=8'h03, SPI_CMD_WRITE=8'h02, SPI_CMD_FAST_READ=8'h0B
  - phase bit-length constants
- One sub-module, spi_bit_engine: clock divider, 8/16-bit shift register, bit counter and sclk/mosi/miso timing. It raises phase_done to the FSM in spi_mem_ctrl.

Test Plan:
- Reset mid-ADDR (rst pulse at cycle 20) → cs_n=1, sclk=0, done=0 within the same cycle; next start performs a full clean transfer.
- Read, CLK_DIV=1: addr=0x1234, we=0, SRAM model byte 0xA5 → mosi stream 0x03,0x12,0x34; rdata=0xA5; done at cycle 66; cs_n low for exactly 64 cycles.
- Write, CLK_DIV=2: addr=0x00FF, wdata=0x3C → mosi stream 0x02,0x00,0xFF,0x3C; model memory[0x00FF]=0x3C; rdata unchanged; done at cycle 130.
- Handshake: start held high 10 cycles past done → done held high; start dropped → done=0 and busy=0 on the next edge; no second transfer. Start pulsed 1 cycle → done pulses exactly 1 cycle.
- Mid-transfer changes: addr switched from 0x0001 to 0xFFFF and start dropped at cycle 5 → address sent is 0x0001; transfer completes.
- SPI_FAST_READ_EN defined: read addr=0x8000 → mosi 0x0B,0x80,0x00, then 8 zeros; byte sampled after the dummy phase; done at cycle 82 (CLK_DIV=1).
